// File: rtl/window_gen_pkg.sv
// window_gen_pkg: shared types, widths and parameter limits for window_generator
package window_gen_pkg;
  typedef enum logic [1:0] {FILL, STREAM, DONE} state_t;
  localparam int SUPPORTED_KERNEL = 3;
  function automatic int col_w(input int w);
    return $clog2(w);
  endfunction
  function automatic int row_w(input int h);
    return $clog2(h);
  endfunction
endpackage

// File: rtl/line_buffer.sv
// line_buffer: one-row delay shift memory; q is the pixel accepted IMG_WIDTH shifts ago
module line_buffer #(
  parameter int DATA_SIZE = 8,
  parameter int IMG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DATA_SIZE-1:0] d,
  output logic [DATA_SIZE-1:0] q
);
  logic [IMG_WIDTH-1:0][DATA_SIZE-1:0] mem;
  always_ff @(posedge clk or posedge rst)
    if (rst) mem <= '0;
    else if (en) mem <= {mem[IMG_WIDTH-2:0], d};
  assign q = mem[IMG_WIDTH-1];
endmodule

// File: rtl/window_generator.sv
// window_generator: raster pixel stream to 3x3 valid-convolution windows
module window_generator
  import window_gen_pkg::*;
#(
  parameter int DATA_SIZE   = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8
) (
  input  logic                                                 i_clk,
  input  logic                                                 i_rst,
  input  logic                                                 i_valid,
  input  logic                                                 i_sof,
  input  logic [DATA_SIZE-1:0]                                 i_data,
  output logic                                                 o_ready,
  output logic                                                 o_valid,
  output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_SIZE-1:0] o_window,
  input  logic                                                 i_ready,
  output logic                                                 o_frame_done
);
  localparam int COL_W = col_w(IMG_WIDTH);
  localparam int ROW_W = row_w(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  if (KERNEL_SIZE != SUPPORTED_KERNEL || IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_bad_params
    $error("window_generator: unsupported KERNEL_SIZE/IMG_WIDTH/IMG_HEIGHT");
  end
  state_t state, state_nxt;
  logic [COL_W-1:0] col, col_nxt, ec;
  logic [ROW_W-1:0] row, row_nxt, er;
  logic acc, hs, eol, emit;
  logic [DATA_SIZE-1:0] up1, up2;
  assign o_ready = !o_valid || i_ready;
  assign acc = i_valid && o_ready;
  assign hs = o_valid && i_ready;
  assign o_frame_done = hs && state == DONE;
  line_buffer #(.DATA_SIZE(DATA_SIZE), .IMG_WIDTH(IMG_WIDTH)) u_lb1 (
    .clk(i_clk), .rst(i_rst), .en(acc), .d(i_data), .q(up1)
  );
  line_buffer #(.DATA_SIZE(DATA_SIZE), .IMG_WIDTH(IMG_WIDTH)) u_lb2 (
    .clk(i_clk), .rst(i_rst), .en(acc), .d(up1), .q(up2)
  );
  // a start-of-frame pixel is positioned at (0,0) regardless of the counters
  always_comb begin
    ec = i_sof ? '0 : col;
    er = i_sof ? '0 : row;
    eol = ec == COL_LAST;
    emit = er >= ROW_W'(2) && ec >= COL_W'(2);
    col_nxt = col;
    row_nxt = row;
    state_nxt = hs && state == DONE ? FILL : state;
    if (acc) begin
      col_nxt = eol ? '0 : ec + 1'b1;
      row_nxt = !eol ? er : er == ROW_LAST ? '0 : er + 1'b1;
      state_nxt = i_sof ? FILL : !eol ? state_nxt : er == ROW_W'(1) ? STREAM : er == ROW_LAST ? DONE : state_nxt;
    end
  end
  // window rows shift left; the new column is {two rows up, one row up, current}
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= FILL;
      col <= '0;
      row <= '0;
      o_valid <= 1'b0;
      o_window <= '0;
    end else begin
      state <= state_nxt;
      col <= col_nxt;
      row <= row_nxt;
      o_valid <= acc ? emit : o_valid && !i_ready;
      if (acc) begin
        o_window[0] <= {up2, o_window[0][2:1]};
        o_window[1] <= {up1, o_window[1][2:1]};
        o_window[2] <= {i_data, o_window[2][2:1]};
      end
    end
endmodule

// File: tb/tb_window_generator.sv
// tb_window_generator: directed 4x4 scenarios plus randomized 8x8 frames against a window model
module tb_window_generator;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic a_rst, a_valid, a_sof, a_ready, a_ovalid, a_iready, a_fd;
  logic [7:0] a_data;
  logic [2:0][2:0][7:0] a_win;
  logic b_rst, b_valid, b_sof, b_ready, b_ovalid, b_iready, b_fd;
  logic [7:0] b_data;
  logic [2:0][2:0][7:0] b_win;
  window_generator #(.DATA_SIZE(8), .KERNEL_SIZE(3), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_valid(a_valid), .i_sof(a_sof), .i_data(a_data),
    .o_ready(a_ready), .o_valid(a_ovalid), .o_window(a_win), .i_ready(a_iready),
    .o_frame_done(a_fd)
  );
  window_generator #(.DATA_SIZE(8), .KERNEL_SIZE(3), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_valid(b_valid), .i_sof(b_sof), .i_data(b_data),
    .o_ready(b_ready), .o_valid(b_ovalid), .o_window(b_win), .i_ready(b_iready),
    .o_frame_done(b_fd)
  );
  int n_chk = 0, n_err = 0;
  logic [71:0] a_got[$], b_got[$], exp_w[$];
  bit a_gotf[$], b_gotf[$], exp_f[$];
  int a_fdn = 0, b_fdn = 0;
  int pix[$];
  int fpix[3][64];
  bit done;
  always @(negedge clk) begin
    if (a_ovalid && a_iready) begin
      a_got.push_back(a_win);
      a_gotf.push_back(a_fd);
    end
    if (b_ovalid && b_iready) begin
      b_got.push_back(b_win);
      b_gotf.push_back(b_fd);
    end
    if (a_fd) a_fdn++;
    if (b_fd) b_fdn++;
  end
  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask
  function automatic logic [71:0] w9(input int p[9]);
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = 8'(p[k]);
    return r;
  endfunction
  // every window of a frame: bottom-right corner over rows/cols 2..edge, raster order
  task automatic model(input int fp[$], input int w, input int h);
    logic [71:0] e;
    for (int r = 2; r < h; r++)
      for (int c = 2; c < w; c++) begin
        for (int k = 0; k < 9; k++) e[k*8 +: 8] = 8'(fp[(r - 2 + k / 3) * w + c - 2 + k % 3]);
        exp_w.push_back(e);
        exp_f.push_back(r == h - 1 && c == w - 1);
      end
  endtask
  task automatic build(input int base);
    pix.delete();
    for (int i = 0; i < 16; i++) pix.push_back(base + i);
  endtask
  task automatic a_clear();
    a_got.delete();
    a_gotf.delete();
    exp_w.delete();
    exp_f.delete();
    a_fdn = 0;
  endtask
  task automatic a_push(input int px, input bit sof);
    bit ok;
    int n;
    n = 0;
    a_valid = 1'b1;
    a_data = 8'(px);
    a_sof = sof;
    do begin
      @(negedge clk);
      ok = a_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 500);
    check($sformatf("a_accept_px%0d", px), 72'(ok), 72'(1));
    a_valid = 1'b0;
    a_sof = 1'b0;
  endtask
  task automatic b_push(input int px, input bit sof);
    bit ok;
    int n;
    n = 0;
    b_valid = 1'b1;
    b_data = 8'(px);
    b_sof = sof;
    do begin
      @(negedge clk);
      ok = b_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 500);
    if (!ok) check("b_accept_timeout", 72'(ok), 72'(1));
    b_valid = 1'b0;
    b_sof = 1'b0;
  endtask
  task automatic a_frame(input int base, input bit sof);
    for (int i = 0; i < 16; i++) a_push(base + i, sof && i == 0);
  endtask
  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask
  task automatic compare(input string tag, input logic [71:0] got[$], input bit gf[$],
                         input int fdn, input int exp_fdn);
    check({tag, "_count"}, 72'(got.size()), 72'(exp_w.size()));
    for (int i = 0; i < got.size() && i < exp_w.size(); i++) begin
      check($sformatf("%s_win%0d", tag, i), got[i], exp_w[i]);
      check($sformatf("%s_fd%0d", tag, i), 72'(gf[i]), 72'(exp_f[i]));
    end
    check({tag, "_fd_pulses"}, 72'(fdn), 72'(exp_fdn));
  endtask
  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_valid = 1'b0; a_sof = 1'b0; a_data = '0; a_iready = 1'b1;
    b_valid = 1'b0; b_sof = 1'b0; b_data = '0; b_iready = 1'b1;
    #2;
    check("rst_valid", 72'(a_ovalid), 72'(0));
    check("rst_window", 72'(a_win), 72'(0));
    check("rst_fd", 72'(a_fd), 72'(0));
    check("rst_b_valid", 72'(b_ovalid), 72'(0));
    @(posedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 72'(a_ready), 72'(1));
    check("rst_b_ready", 72'(b_ready), 72'(1));
    @(posedge clk);
    #1;
    // back-to-back single frame
    a_clear(); build(0); model(pix, 4, 4);
    a_frame(0, 1'b0);
    drain();
    compare("s1", a_got, a_gotf, a_fdn, 1);
    check("s1_first", a_got[0], w9('{0, 1, 2, 4, 5, 6, 8, 9, 10}));
    check("s1_fourth", a_got[3], w9('{5, 6, 7, 9, 10, 11, 13, 14, 15}));
    // downstream stall after the first window
    a_clear(); build(0); model(pix, 4, 4);
    for (int i = 0; i <= 10; i++) a_push(i, 1'b0);
    a_iready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("s2_hold_win", a_win, w9('{0, 1, 2, 4, 5, 6, 8, 9, 10}));
      check("s2_hold_valid", 72'(a_ovalid), 72'(1));
      check("s2_ready_low", 72'(a_ready), 72'(0));
    end
    @(posedge clk);
    #1;
    a_iready = 1'b1;
    for (int i = 11; i < 16; i++) a_push(i, 1'b0);
    drain();
    compare("s2", a_got, a_gotf, a_fdn, 1);
    // two frames back to back
    a_clear();
    build(0); model(pix, 4, 4);
    build(100); model(pix, 4, 4);
    a_frame(0, 1'b1);
    a_frame(100, 1'b1);
    drain();
    compare("s3", a_got, a_gotf, a_fdn, 2);
    check("s3_fifth", a_got[4], w9('{100, 101, 102, 104, 105, 106, 108, 109, 110}));
    // mid-frame restart on pixel 7
    a_clear(); build(50); model(pix, 4, 4);
    for (int i = 0; i < 7; i++) a_push(i, 1'b0);
    a_push(50, 1'b1);
    for (int i = 51; i < 66; i++) a_push(i, 1'b0);
    drain();
    compare("s4", a_got, a_gotf, a_fdn, 1);
    check("s4_topleft", 72'(a_got[0][7:0]), 72'(50));
    // asynchronous reset with a window in flight
    a_clear();
    for (int i = 0; i <= 10; i++) a_push(i, 1'b0);
    a_rst = 1'b1;
    #1;
    check("s5_valid", 72'(a_ovalid), 72'(0));
    check("s5_window", 72'(a_win), 72'(0));
    check("s5_ready", 72'(a_ready), 72'(1));
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    @(posedge clk);
    #1;
    a_clear(); build(0); model(pix, 4, 4);
    a_frame(0, 1'b0);
    drain();
    compare("s5", a_got, a_gotf, a_fdn, 1);
    // random gaps and stalls over three 8x8 frames
    exp_w.delete(); exp_f.delete();
    b_got.delete(); b_gotf.delete(); b_fdn = 0;
    for (int f = 0; f < 3; f++) begin
      pix.delete();
      for (int i = 0; i < 64; i++) begin
        fpix[f][i] = int'($urandom_range(0, 255));
        pix.push_back(fpix[f][i]);
      end
      model(pix, 8, 8);
    end
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 3; f++)
          for (int i = 0; i < 64; i++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            b_push(fpix[f][i], i == 0 && $urandom_range(0, 1) == 1);
          end
        done = 1'b1;
      end
      begin
        while (!done) begin
          b_iready = $urandom_range(0, 9) < 6;
          @(posedge clk);
          #1;
        end
        b_iready = 1'b1;
      end
    join
    drain();
    compare("s6", b_got, b_gotf, b_fdn, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
